adlv_resolve_31: RTL and testbench
==================================

Name: adlv_resolve_31

Overview:
- Consumes the redundant sum/error vector pair produced by the 31-bit level adder array (s = sum bits, e = carry-out bits per position).
- Resolves the pair into a single binary value by sequential carry propagation, CHUNK bits per cycle.
- Sits between the adder array output and downstream binary consumers (comparators, accumulators).
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 31, width of the s and e input vectors.
- CHUNK, 8, bits resolved per RUN cycle; NCHUNK = ceil((WIDTH+2)/CHUNK) = 5 at defaults.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  s_in/e_in valid.
- in_ready  out  1  block can accept a pair.
- s_in  in  WIDTH  redundant sum bits.
- e_in  in  WIDTH  redundant carry bits; e_in[i] has weight 2^(i+1).
- out_valid  out  1  sum_out valid.
- out_ready  in  1  downstream accepts sum_out.
- sum_out  out  WIDTH+2  resolved value = s_in + (e_in << 1), zero-extended.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; in_ready=0 during reset then 1; out_valid=0; sum_out=0; busy=0; chunk counter=0; carry=0. Reset mid-RUN/DONE discards the operation with no output.
- Operand registers: a = {2'b0, s_in}, b = {1'b0, e_in, 1'b0}, both WIDTH+2 bits, loaded on in_fire = in_valid & in_ready.
- FSM:
  - IDLE: in_ready=1. On in_fire, load operands, cnt=0, carry=0, go to RUN.
  - RUN: in_ready=0. Each edge adds a[cnt*CHUNK +: CHUNK] + b[same] + carry, writes that slice of sum_out, updates carry, cnt++.
  - RUN exit: after the final chunk (cnt = NCHUNK-1), go to DONE and set out_valid=1. The final chunk is partial when (WIDTH+2) mod CHUNK != 0; bits above WIDTH+1 are ignored.
  - DONE: out_valid=1 and sum_out held stable until out_ready. On out_valid & out_ready, go to IDLE and clear out_valid. No same-cycle reload: in_ready stays 0 in DONE.
- Latency: with in_fire at edge E0, out_valid is first high after edge E0+NCHUNK (5 cycles at defaults).
- Throughput: one result per NCHUNK+2 cycles with out_ready tied high.
- Carry out of the top chunk is always 0 by construction; no overflow flag.
- in_valid while in_ready=0 is ignored. The source must hold its data until accepted.
- sum_out bits not yet written in RUN hold their previous-op values. Consumers sample only when out_valid=1.

Optional Feature:
- Macro: ADLV_RESOLVE_ERRCNT_EN.
- With the macro: extra output err_cnt, width $clog2(WIDTH+1).
  - Holds the popcount of e_in, registered on in_fire.
  - Valid with out_valid; reset value 0.
  - Indicates how many positions produced a carry.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package adlv_pkg:
  - WIDTH_DEFAULT=31 and CHUNK_DEFAULT=8.
  - State enum {IDLE, RUN, DONE}.
  - NCHUNK computation function.
- One sub-module, adlv_chunk_add: CHUNK-bit combinational adder with a, b, cin in and sum, cout out. Instantiated once and reused every RUN cycle.

Test Plan:
- Reset mid-RUN: load s=31'h7FFFFFFF, e=31'h7FFFFFFF, assert rst_n=0 at RUN cycle 2 -> state IDLE, out_valid never rises, busy=0, sum_out=0.
- Basic: s=31'h000000FF, e=31'h00000001, out_ready=1 -> out_valid exactly 5 cycles after in_fire, sum_out=33'h000000101; ERRCNT_EN: err_cnt=1.
- Full-scale: s=31'h7FFFFFFF, e=31'h7FFFFFFF -> sum_out=33'h17FFFFFFD; ERRCNT_EN: err_cnt=31.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum_out stable, in_ready=0 throughout, and in_valid pulses during that time are not accepted. Release -> IDLE next edge, in_ready=1.
- Back-to-back: 100 random pairs with in_valid always high and random out_ready -> every sum_out equals s+(e<<1) in order, with no drops or duplicates.
- Zero: s=0, e=0 -> sum_out=0, out_valid after 5 cycles; ERRCNT_EN: err_cnt=0.

Source files
------------

// File: rtl/adlv_resolve_31_pkg.sv
// Shared types and sizing helpers for the redundant-to-binary resolver.
// Pure declarations: no latency, no backpressure.
// The ready/valid behaviour is defined by the modules that import this package.
package adlv_pkg;
    localparam int WIDTH_DEFAULT = 31;
    localparam int CHUNK_DEFAULT = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // The resolved value is WIDTH+2 bits wide, split into CHUNK-bit slices.
    function automatic int nchunk(input int width, input int chunk);
        return (width + 2 + chunk - 1) / chunk;
    endfunction
endpackage

// File: rtl/adlv_resolve_31_if.sv
// Ready/valid bundle between the adder array, the resolver and its consumer.
// Wires only: no latency.
// Backpressure is carried on in_ready and out_ready.
interface adlv_resolve_31_if
    import adlv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] e_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] sum_out;

    modport master (
        output in_valid, s_in, e_in, out_ready,
        input  in_ready, out_valid, sum_out
    );

    modport slave (
        input  in_valid, s_in, e_in, out_ready,
        output in_ready, out_valid, sum_out
    );
endinterface

// File: rtl/adlv_chunk_add.sv
// CHUNK-bit ripple slice of the resolver: a + b + cin.
// Combinational, zero latency.
// No backpressure; the caller sequences the slices.
module adlv_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);
endmodule

// File: rtl/adlv_resolve_31.sv
// Resolves a (sum, carry) redundant pair into s + (e << 1), CHUNK bits per cycle.
// Latency: out_valid rises NCHUNK edges after in_fire; one result per NCHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Option: ADLV_RESOLVE_ERRCNT_EN.
module adlv_resolve_31
    import adlv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    adlv_resolve_31_if.slave   bus,
    output logic               busy
`ifdef ADLV_RESOLVE_ERRCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] err_cnt
`endif
);
    localparam int W2  = WIDTH + 2;
    localparam int NCH = nchunk(WIDTH, CHUNK);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [W2-1:0] SLICE_MASK = W2'({CHUNK{1'b1}});

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic [WIDTH-1:0]  s_r, e_r;
    logic [W2-1:0]     sum_r;
    logic              in_fire;
    logic              last_chunk;

    logic [W2-1:0]     a_full, b_full, sum_upd;
    logic [CHUNK-1:0]  a_chk, b_chk, s_chk;
    logic              c_out;
    int                shamt;

    assign in_fire    = bus.in_valid & bus.in_ready;
    assign last_chunk = (cnt == CW'(NCH - 1));
    assign a_full     = {2'b0, s_r};
    assign b_full     = {1'b0, e_r, 1'b0};

    // Slice selection by shifting; the top slice zero-fills and its excess bits fall off.
    always_comb begin
        shamt   = int'(cnt) * CHUNK;
        a_chk   = CHUNK'(a_full >> shamt);
        b_chk   = CHUNK'(b_full >> shamt);
        sum_upd = (sum_r & ~(SLICE_MASK << shamt)) | (W2'(s_chk) << shamt);
    end

    adlv_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (a_chk),
        .b    (b_chk),
        .cin  (carry),
        .sum  (s_chk),
        .cout (c_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = rst_n;
                if (in_fire) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) state_nx = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            s_r   <= '0;
            e_r   <= '0;
            sum_r <= '0;
        end else begin
            case (state)
                IDLE: if (in_fire) begin
                    s_r   <= bus.s_in;
                    e_r   <= bus.e_in;
                    cnt   <= '0;
                    carry <= 1'b0;
                end
                RUN: begin
                    sum_r <= sum_upd;
                    carry <= c_out;
                    cnt   <= last_chunk ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sum_out = sum_r;

`ifdef ADLV_RESOLVE_ERRCNT_EN
    localparam int ECW = $clog2(WIDTH + 1);
    logic [ECW-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + ECW'(bus.e_in[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       err_cnt <= '0;
        else if (in_fire) err_cnt <= pop;
    end
`endif
endmodule

// File: tb/tb_adlv_resolve_31.sv
// Randomised and directed bench for adlv_resolve_31 against a queue-based reference model.
// Expected results come from s + 2*e and a fixed NCHUNK+1 observation delay.
module tb_adlv_resolve_31;
    localparam int WIDTH  = 31;
    localparam int NCHUNK = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef ADLV_RESOLVE_ERRCNT_EN
    logic [4:0] err_cnt;
`endif

    adlv_resolve_31_if #(.WIDTH(WIDTH)) bus ();

    adlv_resolve_31 #(.WIDTH(WIDTH), .CHUNK(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy)
`ifdef ADLV_RESOLVE_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] sum;
        int          pop;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   nvec   = 0;
    int   nerr   = 0;
    int   cyc    = 0;
    int   ndeliv = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_sum(input logic [30:0] s, input logic [30:0] e);
        return 33'(s) + (33'(e) << 1);
    endfunction

    // Reference: an accepted pair is outstanding until its result is handed over.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(q.size() != 0));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    chk("sum_out", 64'(bus.sum_out), 64'(q[0].sum));
`ifdef ADLV_RESOLVE_ERRCNT_EN
                    chk("err_cnt", 64'(err_cnt), 64'(q[0].pop));
`endif
                    if (!prev_ov) chk("latency", 64'(cyc - q[0].cyc), 64'(NCHUNK + 1));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        ndeliv++;
                    end
                end
            end
            prev_ov = bus.out_valid;
            if (bus.in_valid && bus.in_ready)
                q.push_back('{sum: model_sum(bus.s_in, bus.e_in), pop: $countones(bus.e_in), cyc: cyc});
        end
    end

    task automatic send(input logic [30:0] s, input logic [30:0] e);
        int k;
        @(posedge clk); #1;
        bus.s_in = s;
        bus.e_in = e;
        bus.in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("send_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #300000;
        chk("watchdog", 64'd1, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sent;
        int base;
        logic fired;

        bus.in_valid  = 1'b0;
        bus.s_in      = '0;
        bus.e_in      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum_out", 64'(bus.sum_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Reset in the middle of RUN discards the operation
        send(31'h7FFFFFFF, 31'h7FFFFFFF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_out_valid", 64'(bus.out_valid), 64'd0);
        end
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sum_out", 64'(bus.sum_out), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic
        send(31'h000000FF, 31'h00000001);
        wait_ov(n);
        chk("basic_latency", 64'(n), 64'd5);
        chk("basic_sum", 64'(bus.sum_out), 64'h000000101);
`ifdef ADLV_RESOLVE_ERRCNT_EN
        chk("basic_err_cnt", 64'(err_cnt), 64'd1);
`endif

        // Full-scale
        send(31'h7FFFFFFF, 31'h7FFFFFFF);
        wait_ov(n);
        chk("full_latency", 64'(n), 64'd5);
        chk("full_sum", 64'(bus.sum_out), 64'h17FFFFFFD);
`ifdef ADLV_RESOLVE_ERRCNT_EN
        chk("full_err_cnt", 64'(err_cnt), 64'd31);
`endif

        // Zero
        send(31'h0, 31'h0);
        wait_ov(n);
        chk("zero_latency", 64'(n), 64'd5);
        chk("zero_sum", 64'(bus.sum_out), 64'd0);
`ifdef ADLV_RESOLVE_ERRCNT_EN
        chk("zero_err_cnt", 64'(err_cnt), 64'd0);
`endif

        // Backpressure: result held, further pairs refused
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(31'h12345678, 31'h0F0F0F0F);
        wait_ov(n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid = (i % 2 == 0);
            bus.s_in = 31'($urandom);
            bus.e_in = 31'($urandom);
            @(negedge clk);
            chk("bp_sum_stable", 64'(bus.sum_out), 64'h030527496);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

        // Back-to-back random traffic with random downstream stalls
        base = ndeliv;
        sent = 0;
        @(posedge clk); #1;
        bus.s_in = 31'($urandom);
        bus.e_in = 31'($urandom);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 5000 && sent < 100; t++) begin
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fired) begin
                sent++;
                bus.s_in = 31'($urandom);
                bus.e_in = 31'($urandom);
                if (sent >= 100) bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        chk("rand_sent", 64'(sent), 64'd100);
        chk("rand_delivered", 64'(ndeliv - base), 64'd100);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
